// File: rtl/lotr_pkg.sv
// Shared definitions for the DE10-Lite front end.
// Holds the board debounce constant and the bundle type that carries the
// conditioned inputs from the debouncer to the MMIO CR block.
package lotr_pkg;

  // 10 ms of stable level at 50 MHz
  localparam int DEBOUNCE_CYCLES_DE10 = 500000;

  // Two flops are enough for the 50 MHz domain
  localparam int SYNC_STAGES_DE10 = 2;

  // SW[9:0] on the DE10-Lite
  localparam int NUM_SWITCHES = 10;

  // Conditioned board inputs, one bundle for the top level
  typedef struct packed {
    logic                    Button_0;
    logic                    Button_1;
    logic [NUM_SWITCHES-1:0] Switch;
  } t_fpga_inputs;

  // Idle pad level for a button, so the synchronizer starts out "released"
  function automatic logic f_buttonIdleLevel(input logic activeLow);
    return activeLow;
  endfunction

endpackage

// File: rtl/fpga_input_debounce_bit.sv
// Single-channel input conditioner: synchronizer, optional polarity fix,
// stable-level debouncer and registered change/rise strobes.
// The strobes are high in the first cycle the new level is visible on Level.
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_LEVEL     = 1'b0,
  parameter logic INVERT          = 1'b0
) (
  input  logic CLK_50,
  input  logic RstQnnnH,
  input  logic Raw,
  output logic Level,
  output logic Rise,
  output logic Change
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_change;

  logic                   w_sync;
  logic [CNT_W-1:0]       w_cntNext;
  logic                   w_stableNext;
  logic                   w_riseNext;
  logic                   w_changeNext;

  // Synchronizer chain; resets to the idle pad level so release never looks like an edge
  always_ff @(posedge CLK_50 or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Raw};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1] ^ INVERT;

  // Debounce decision: count disagreeing cycles, commit on terminal count
  always_comb begin
    w_cntNext    = r_cnt;
    w_stableNext = r_stable;
    w_riseNext   = 1'b0;
    w_changeNext = 1'b0;
    if (w_sync == r_stable) begin
      w_cntNext = '0;
    end else if (r_cnt == TERMINAL) begin
      w_cntNext    = '0;
      w_stableNext = w_sync;
      w_changeNext = 1'b1;
      w_riseNext   = w_sync;
    end else begin
      w_cntNext = r_cnt + 1'b1;
    end
  end

  // Debounce state and strobe registers
  always_ff @(posedge CLK_50 or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_cnt    <= w_cntNext;
      r_stable <= w_stableNext;
      r_rise   <= w_riseNext;
      r_change <= w_changeNext;
    end
  end

  assign Level  = r_stable;
  assign Rise   = r_rise;
  assign Change = r_change;

endmodule

// File: rtl/fpga_input_debounce.sv
// Conditions KEY0, KEY1 and SW[9:0] for the MMIO CR block: every pad gets
// its own synchronizer and debouncer, buttons are flipped so pressed reads 1,
// and the press/change event pulses are gathered here.
module fpga_input_debounce
  import lotr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DE10,
  parameter int SYNC_STAGES       = SYNC_STAGES_DE10,
  parameter int BUTTON_ACTIVE_LOW = 1
) (
  input  logic       CLK_50,
  input  logic       RstQnnnH,
  input  logic       Button_0_Raw,
  input  logic       Button_1_Raw,
  input  logic [9:0] Switch_Raw,
  output logic       Button_0,
  output logic       Button_1,
  output logic [9:0] Switch,
  output logic       Button_0_Press,
  output logic       Button_1_Press,
  output logic       Switch_Change
);

  localparam logic BTN_INVERT = (BUTTON_ACTIVE_LOW != 0);
  localparam logic BTN_IDLE   = f_buttonIdleLevel(BTN_INVERT);

  t_fpga_inputs            w_levels;
  logic                    w_btn0Rise;
  logic                    w_btn1Rise;
  logic                    w_btn0Change;
  logic                    w_btn1Change;
  logic [NUM_SWITCHES-1:0] w_swRise;
  logic [NUM_SWITCHES-1:0] w_swChange;
  logic                    w_unusedStrobes;

  debounce_bit #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .RESET_LEVEL     (BTN_IDLE),
    .INVERT          (BTN_INVERT)
  ) u_button0 (
    .CLK_50   (CLK_50),
    .RstQnnnH (RstQnnnH),
    .Raw      (Button_0_Raw),
    .Level    (w_levels.Button_0),
    .Rise     (w_btn0Rise),
    .Change   (w_btn0Change)
  );

  debounce_bit #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .RESET_LEVEL     (BTN_IDLE),
    .INVERT          (BTN_INVERT)
  ) u_button1 (
    .CLK_50   (CLK_50),
    .RstQnnnH (RstQnnnH),
    .Raw      (Button_1_Raw),
    .Level    (w_levels.Button_1),
    .Rise     (w_btn1Rise),
    .Change   (w_btn1Change)
  );

  // Switches idle low and are never inverted
  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_switch
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .RESET_LEVEL     (1'b0),
      .INVERT          (1'b0)
    ) u_switch (
      .CLK_50   (CLK_50),
      .RstQnnnH (RstQnnnH),
      .Raw      (Switch_Raw[g]),
      .Level    (w_levels.Switch[g]),
      .Rise     (w_swRise[g]),
      .Change   (w_swChange[g])
    );
  end

  assign Button_0       = w_levels.Button_0;
  assign Button_1       = w_levels.Button_1;
  assign Switch         = w_levels.Switch;
  assign Button_0_Press = w_btn0Rise;
  assign Button_1_Press = w_btn1Rise;

  // Each strobe is already a single registered cycle, so several switches
  // changing together still merge into one pulse
  assign Switch_Change  = |w_swChange;

  // Button change and switch rise strobes have no consumer at this level
  assign w_unusedStrobes = &{1'b0, w_btn0Change, w_btn1Change, w_swRise};

endmodule

// File: tb/tb_fpga_input_debounce.sv
// Directed bench for fpga_input_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge, so "edge k" is the k-th rising edge after a change.
module tb_fpga_input_debounce;

  logic       CLK_50 = 1'b0;
  logic       RstQnnnH;
  logic       Button_0_Raw;
  logic       Button_1_Raw;
  logic [9:0] Switch_Raw;
  logic       Button_0;
  logic       Button_1;
  logic [9:0] Switch;
  logic       Button_0_Press;
  logic       Button_1_Press;
  logic       Switch_Change;

  int nAsserts = 0;
  int nFails   = 0;

  fpga_input_debounce #(
    .DEBOUNCE_CYCLES   (4),
    .SYNC_STAGES       (2),
    .BUTTON_ACTIVE_LOW (1)
  ) dut (
    .CLK_50         (CLK_50),
    .RstQnnnH       (RstQnnnH),
    .Button_0_Raw   (Button_0_Raw),
    .Button_1_Raw   (Button_1_Raw),
    .Switch_Raw     (Switch_Raw),
    .Button_0       (Button_0),
    .Button_1       (Button_1),
    .Switch         (Switch),
    .Button_0_Press (Button_0_Press),
    .Button_1_Press (Button_1_Press),
    .Switch_Change  (Switch_Change)
  );

  // 50 MHz-style free-running clock
  always #5 CLK_50 = ~CLK_50;

  task automatic tick();
    @(posedge CLK_50);
    @(negedge CLK_50);
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    RstQnnnH     = 1'b1;
    Button_0_Raw = 1'b1;
    Button_1_Raw = 1'b1;
    Switch_Raw   = 10'h000;
    repeat (3) tick();
    obs = {Button_0, Button_1, Switch, Button_0_Press, Button_1_Press, Switch_Change};
    nAsserts++;
    if (obs !== 15'h0) begin
      nFails++;
      $display("[TB] FAIL reset_held: outputs got %0h expected 0", obs);
    end
    RstQnnnH = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      obs = {Button_0, Button_1, Switch, Button_0_Press, Button_1_Press, Switch_Change};
      nAsserts++;
      if (obs !== 15'h0) begin
        nFails++;
        $display("[TB] FAIL reset_quiet edge %0d: outputs got %0h expected 0", k, obs);
      end
    end
  endtask

  task automatic test_press_release();
    Button_0_Raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      nAsserts++;
      if (Button_0 !== (k >= 6)) begin
        nFails++;
        $display("[TB] FAIL press_level edge %0d: got %b expected %b", k, Button_0, (k >= 6));
      end
      nAsserts++;
      if (Button_0_Press !== (k == 6)) begin
        nFails++;
        $display("[TB] FAIL press_pulse edge %0d: got %b expected %b", k, Button_0_Press, (k == 6));
      end
    end
    Button_0_Raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      nAsserts++;
      if (Button_0 !== (k < 6)) begin
        nFails++;
        $display("[TB] FAIL release_level edge %0d: got %b expected %b", k, Button_0, (k < 6));
      end
      nAsserts++;
      if (Button_0_Press !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL release_pulse edge %0d: got %b expected 0", k, Button_0_Press);
      end
    end
  endtask

  task automatic test_bounce();
    Button_1_Raw = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 3) Button_1_Raw = 1'b1;
      nAsserts++;
      if ({Button_1, Button_1_Press} !== 2'b00) begin
        nFails++;
        $display("[TB] FAIL bounce edge %0d: level/press got %b%b expected 00", k, Button_1, Button_1_Press);
      end
    end
  endtask

  task automatic test_switch();
    logic [9:0] exp;
    Switch_Raw = 10'h281;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6) ? 10'h281 : 10'h000;
      nAsserts++;
      if (Switch !== exp) begin
        nFails++;
        $display("[TB] FAIL switch_281 edge %0d: got %h expected %h", k, Switch, exp);
      end
      nAsserts++;
      if (Switch_Change !== (k == 6)) begin
        nFails++;
        $display("[TB] FAIL switch_change1 edge %0d: got %b expected %b", k, Switch_Change, (k == 6));
      end
    end
    Switch_Raw = 10'h280;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6) ? 10'h280 : 10'h281;
      nAsserts++;
      if (Switch !== exp) begin
        nFails++;
        $display("[TB] FAIL switch_280 edge %0d: got %h expected %h", k, Switch, exp);
      end
      nAsserts++;
      if (Switch_Change !== (k == 6)) begin
        nFails++;
        $display("[TB] FAIL switch_change2 edge %0d: got %b expected %b", k, Switch_Change, (k == 6));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp;
    Button_0_Raw = 1'b0;
    // Two sync edges plus two counting edges leaves the counter at 2
    repeat (4) tick();
    RstQnnnH = 1'b1;
    #1;
    nAsserts++;
    if ({Button_0, Button_0_Press, Switch} !== 12'h000) begin
      nFails++;
      $display("[TB] FAIL reset_async: got %h expected 000", {Button_0, Button_0_Press, Switch});
    end
    @(negedge CLK_50);
    repeat (2) begin
      tick();
      nAsserts++;
      if (Button_0 !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL reset_mid_held: got %b expected 0", Button_0);
      end
    end
    RstQnnnH = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6) ? 10'h280 : 10'h000;
      nAsserts++;
      if (Button_0 !== (k >= 6) || Button_0_Press !== (k == 6)) begin
        nFails++;
        $display("[TB] FAIL requalify_button edge %0d: level/press got %b%b expected %b%b",
                 k, Button_0, Button_0_Press, (k >= 6), (k == 6));
      end
      nAsserts++;
      if (Switch !== exp || Switch_Change !== (k == 6)) begin
        nFails++;
        $display("[TB] FAIL requalify_switch edge %0d: got %h/%b expected %h/%b",
                 k, Switch, Switch_Change, exp, (k == 6));
      end
    end
    Button_0_Raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      nAsserts++;
      if (Button_0 !== (k < 6) || Button_0_Press !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL requalify_release edge %0d: level/press got %b%b expected %b0",
                 k, Button_0, Button_0_Press, (k < 6));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    Button_0_Raw = 1'b0;
    Switch_Raw   = 10'h288;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 6) ? 10'h288 : 10'h280;
      nAsserts++;
      if (Button_0_Press !== (k == 6) || Switch_Change !== (k == 6)) begin
        nFails++;
        $display("[TB] FAIL same_edge_pulses edge %0d: press/change got %b%b expected %b%b",
                 k, Button_0_Press, Switch_Change, (k == 6), (k == 6));
      end
      nAsserts++;
      if (Switch !== exp || Button_0 !== (k >= 6)) begin
        nFails++;
        $display("[TB] FAIL same_edge_levels edge %0d: got %h/%b expected %h/%b",
                 k, Switch, Button_0, exp, (k >= 6));
      end
    end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] starting fpga_input_debounce bench");
    test_reset();
    test_press_release();
    test_bounce();
    test_switch();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
